uart8: RTL and testbench

UART8 -- requirements
Module: uart8

---
 rtl/uart8.sv | 210 +++++++++++++++++++++
 tb/tb_uart8.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart8.sv
// 8N1 UART: free-running baud divider for TX, 16x oversampling receiver with
// a 2-flop input synchronizer. Both directions are independent FSMs.
module uart8 #(
  parameter int CLOCK_RATE = 12000000,
  parameter int BAUD_RATE  = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxEn,
  input  logic       rx,
  output logic       rxBusy,
  output logic       rxDone,
  output logic       rxErr,
  output logic [7:0] out,
  input  logic       txEn,
  input  logic       txStart,
  input  logic [7:0] in,
  output logic       txBusy,
  output logic       txDone,
  output logic       tx
);
  localparam int BAUD_DIV = CLOCK_RATE / BAUD_RATE;
  localparam int OS_DIV   = CLOCK_RATE / (16 * BAUD_RATE);
  localparam int BW       = $clog2(BAUD_DIV + 1);
  localparam int OW       = $clog2(OS_DIV + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [BW-1:0] baudCnt;
  logic [OW-1:0] osCnt;
  logic          baudTick, osTick;

  assign baudTick = (baudCnt == BW'(BAUD_DIV - 1));
  assign osTick   = (osCnt == OW'(OS_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baudCnt <= '0;
      osCnt   <= '0;
    end else begin
      baudCnt <= baudTick ? '0 : baudCnt + 1'b1;
      osCnt   <= osTick ? '0 : osCnt + 1'b1;
    end
  end

  // ---------------- transmitter ----------------
  state_t     txState, txStateN;
  logic [7:0] txShift, txShiftN;
  logic [2:0] txBit, txBitN;
  logic       txN, txBusyN, txDoneN;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      txState <= IDLE;
      txShift <= '0;
      txBit   <= '0;
      tx      <= 1'b1;
      txBusy  <= 1'b0;
      txDone  <= 1'b0;
    end else begin
      txState <= txStateN;
      txShift <= txShiftN;
      txBit   <= txBitN;
      tx      <= txN;
      txBusy  <= txBusyN;
      txDone  <= txDoneN;
    end
  end

  always_comb begin
    txStateN = txState;
    txShiftN = txShift;
    txBitN   = txBit;
    txN      = tx;
    txBusyN  = txBusy;
    txDoneN  = txDone;
    if (!txEn) begin
      txStateN = IDLE;
      txN      = 1'b1;
      txBusyN  = 1'b0;
      if (txState != IDLE) txDoneN = 1'b0;
    end else if (baudTick) begin
      case (txState)
        IDLE: if (txStart) begin
          txShiftN = in;
          txN      = 1'b0;
          txBusyN  = 1'b1;
          txDoneN  = 1'b0;
          txStateN = START;
        end
        START: begin
          txN      = txShift[0];
          txShiftN = {1'b0, txShift[7:1]};
          txBitN   = '0;
          txStateN = DATA;
        end
        DATA: if (txBit == 3'd7) begin
          txN      = 1'b1;
          txStateN = STOP;
        end else begin
          txN      = txShift[0];
          txShiftN = {1'b0, txShift[7:1]};
          txBitN   = txBit + 3'd1;
        end
        STOP: if (txStart) begin
          // back-to-back: next start bit follows the single stop bit directly
          txShiftN = in;
          txN      = 1'b0;
          txDoneN  = 1'b0;
          txStateN = START;
        end else begin
          txBusyN  = 1'b0;
          txDoneN  = 1'b1;
          txStateN = IDLE;
        end
        default: txStateN = IDLE;
      endcase
    end
  end

  // ---------------- receiver ----------------
  logic       rxMeta, rxSync;
  state_t     rxState, rxStateN;
  logic [3:0] rxCnt, rxCntN;
  logic [2:0] rxBit, rxBitN;
  logic [7:0] rxShift, rxShiftN, outN;
  logic       rxBusyN, rxDoneN, rxErrN;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxMeta  <= 1'b1;
      rxSync  <= 1'b1;
      rxState <= IDLE;
      rxCnt   <= '0;
      rxBit   <= '0;
      rxShift <= '0;
      out     <= '0;
      rxBusy  <= 1'b0;
      rxDone  <= 1'b0;
      rxErr   <= 1'b0;
    end else begin
      rxMeta  <= rx;
      rxSync  <= rxMeta;
      rxState <= rxStateN;
      rxCnt   <= rxCntN;
      rxBit   <= rxBitN;
      rxShift <= rxShiftN;
      out     <= outN;
      rxBusy  <= rxBusyN;
      rxDone  <= rxDoneN;
      rxErr   <= rxErrN;
    end
  end

  always_comb begin
    rxStateN = rxState;
    rxCntN   = rxCnt;
    rxBitN   = rxBit;
    rxShiftN = rxShift;
    outN     = out;
    rxBusyN  = rxBusy;
    rxDoneN  = rxDone;
    rxErrN   = rxErr;
    if (!rxEn) begin
      rxStateN = IDLE;
      rxBusyN  = 1'b0;
    end else if (osTick) begin
      case (rxState)
        IDLE: if (!rxSync) begin
          rxStateN = START;
          rxCntN   = '0;
          rxBusyN  = 1'b1;
          rxDoneN  = 1'b0;
          rxErrN   = 1'b0;
        end
        START: if (rxCnt == 4'd7) begin
          rxCntN = '0;
          if (rxSync) begin
            rxErrN   = 1'b1;
            rxBusyN  = 1'b0;
            rxStateN = IDLE;
          end else begin
            rxBitN   = '0;
            rxStateN = DATA;
          end
        end else rxCntN = rxCnt + 4'd1;
        DATA: if (rxCnt == 4'd15) begin
          rxCntN   = '0;
          rxShiftN = {rxSync, rxShift[7:1]};
          if (rxBit == 3'd7) rxStateN = STOP;
          else               rxBitN   = rxBit + 3'd1;
        end else rxCntN = rxCnt + 4'd1;
        STOP: if (rxCnt == 4'd15) begin
          rxCntN   = '0;
          rxBusyN  = 1'b0;
          rxStateN = IDLE;
          if (rxSync) begin
            outN    = rxShift;
            rxDoneN = 1'b1;
            rxErrN  = 1'b0;
          end else begin
            rxDoneN = 1'b0;
            rxErrN  = 1'b1;
          end
        end else rxCntN = rxCnt + 4'd1;
        default: rxStateN = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart8.sv
// Two cross-wired uart8 instances; received frames are checked against a
// scoreboard of expected bytes/status pushed when each frame is launched.
module tb_uart8;
  localparam int BAUD = 1250;
  localparam int OS   = 78;

  typedef struct {
    logic [7:0] data;
    logic       done;
    logic       err;
  } exp_t;

  logic clk = 0, reset = 1;
  logic rxEn1, rxBusy1, rxDone1, rxErr1, txEn1, txStart1, txBusy1, txDone1, tx1;
  logic rxEn2, rxBusy2, rxDone2, rxErr2, txEn2, txStart2, txBusy2, txDone2, tx2;
  logic [7:0] out1, in1, out2, in2;
  logic rxSel, tbRx, rx2;

  assign rx2 = rxSel ? tbRx : tx1;

  uart8 u1 (.clk(clk), .reset(reset), .rxEn(rxEn1), .rx(tx2), .rxBusy(rxBusy1),
            .rxDone(rxDone1), .rxErr(rxErr1), .out(out1), .txEn(txEn1),
            .txStart(txStart1), .in(in1), .txBusy(txBusy1), .txDone(txDone1), .tx(tx1));
  uart8 u2 (.clk(clk), .reset(reset), .rxEn(rxEn2), .rx(rx2), .rxBusy(rxBusy2),
            .rxDone(rxDone2), .rxErr(rxErr2), .out(out2), .txEn(txEn2),
            .txStart(txStart2), .in(in2), .txBusy(txBusy2), .txDone(txDone2), .tx(tx2));

  always #42 clk = ~clk;

  int   nCmp = 0, nBad = 0;
  exp_t q1[$], q2[$];
  logic mon1On = 1, mon2On = 1, prevBusy1 = 0, prevBusy2 = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // frame completion = falling rxBusy; compare against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (mon2On && prevBusy2 && !rxBusy2) begin
      if (q2.size() > 0) begin
        e = q2.pop_front();
        chk("rx2.out", out2, e.data);
        chk("rx2.done", rxDone2, e.done);
        chk("rx2.err", rxErr2, e.err);
      end else chk("rx2.unexpectedDone", rxDone2, 0);
    end
    prevBusy2 = rxBusy2;
  end

  always @(negedge clk) begin
    exp_t e;
    if (mon1On && prevBusy1 && !rxBusy1) begin
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("rx1.out", out1, e.data);
        chk("rx1.done", rxDone1, e.done);
        chk("rx1.err", rxErr1, e.err);
      end else chk("rx1.unexpectedDone", rxDone1, 0);
    end
    prevBusy1 = rxBusy1;
  end

  task automatic waitTx1Low();
    int n = 0;
    while (tx1 && n < BAUD + 10) begin
      @(negedge clk);
      n++;
    end
    chk("tx1.startSeen", tx1, 0);
  endtask

  task automatic sendRx(input logic [7:0] d, input logic stopBit);
    tbRx = 0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      tbRx = d[i];
      repeat (BAUD) @(negedge clk);
    end
    tbRx = stopBit;
    repeat (BAUD) @(negedge clk);
    tbRx = 1;
  endtask

  initial begin
    logic [9:0] bits, busy;
    int bad, lat;
    rxEn1 = 1; rxEn2 = 1; txEn1 = 1; txEn2 = 0;
    txStart1 = 0; txStart2 = 0; in1 = 0; in2 = 0;
    rxSel = 0; tbRx = 1;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst.tx1", tx1, 1);
    chk("rst.txBusy1", txBusy1, 0);
    chk("rst.txDone1", txDone1, 0);
    chk("rst.rx2", {rxBusy2, rxDone2, rxErr2, out2}, 0);
    reset = 0;
    repeat (5) @(negedge clk);

    // single frame u1 -> u2, line bit pattern and busy profile
    in1 = 8'b10001010;
    q2.push_back('{data: 8'b10001010, done: 1'b1, err: 1'b0});
    fork
      begin
        txStart1 = 1;
        repeat (BAUD) @(negedge clk);
        txStart1 = 0;
      end
      begin
        waitTx1Low();
        repeat (BAUD / 2) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
          bits[i] = tx1;
          busy[i] = txBusy1;
          repeat (BAUD) @(negedge clk);
        end
      end
    join
    chk("tx1.frameBits", bits, 10'b1100010100);
    chk("tx1.busyProfile", busy, 10'h3FF);
    chk("tx1.busyAfter", txBusy1, 0);
    chk("tx1.doneAfter", txDone1, 1);
    chk("q2.drainA", q2.size(), 0);

    // start requested while disabled, then enabled
    txEn1 = 0; txStart1 = 1; in1 = 8'b01111010;
    q2.push_back('{data: 8'b01111010, done: 1'b1, err: 1'b0});
    bad = 0;
    repeat (288) begin
      @(negedge clk);
      if (!tx1 || txBusy1) bad++;
    end
    chk("tx1.idleWhileDisabled", bad, 0);
    txEn1 = 1;
    lat = 0;
    while (tx1 && lat < BAUD + 10) begin
      @(negedge clk);
      lat++;
    end
    chk("tx1.enLatencyOk", lat <= BAUD, 1);
    txStart1 = 0;
    repeat (10 * BAUD) @(negedge clk);
    chk("q2.drainB", q2.size(), 0);
    chk("rx2.outB", out2, 8'h7A);

    // bad stop bit driven directly on rx2
    rxSel = 1;
    q2.push_back('{data: 8'h7A, done: 1'b0, err: 1'b1});
    sendRx(8'h55, 1'b0);
    repeat (2 * BAUD) @(negedge clk);
    chk("q2.drainC", q2.size(), 0);
    chk("rx2.stopErr", {rxErr2, rxDone2, out2}, {2'b10, 8'h7A});

    // short glitch: 3 oversample ticks low
    q2.push_back('{data: 8'h7A, done: 1'b0, err: 1'b1});
    tbRx = 0;
    repeat (3 * OS) @(negedge clk);
    tbRx = 1;
    repeat (2 * BAUD) @(negedge clk);
    chk("q2.drainD", q2.size(), 0);
    chk("rx2.glitchBusy", rxBusy2, 0);
    rxSel = 0;

    // abort at data bit 4
    mon2On = 0;
    in1 = 8'h3C;
    txStart1 = 1;
    waitTx1Low();
    txStart1 = 0;
    repeat (5 * BAUD + BAUD / 2) @(negedge clk);
    @(posedge clk); #1 txEn1 = 0;
    @(posedge clk); #1;
    chk("abort.tx1", tx1, 1);
    chk("abort.txBusy1", txBusy1, 0);
    chk("abort.txDone1", txDone1, 0);
    repeat (6 * BAUD) @(negedge clk);
    chk("abort.rx2NotGood", rxDone2 && (out2 == 8'h3C), 0);
    chk("abort.rx2Idle", rxBusy2, 0);
    txEn1 = 1;

    // async reset mid-DATA in both directions
    mon1On = 0;
    in1 = 8'hC3; in2 = 8'h96; txEn2 = 1;
    @(negedge clk);
    txStart1 = 1; txStart2 = 1;
    waitTx1Low();
    txStart1 = 0; txStart2 = 0;
    repeat (3 * BAUD) @(negedge clk);
    chk("preRst.busy", {txBusy1, txBusy2, rxBusy1, rxBusy2}, 4'hF);
    #5 reset = 1;
    #1;
    chk("rst.u1", {tx1, txBusy1, txDone1, rxBusy1, rxDone1, rxErr1, out1}, {1'b1, 5'b0, 8'h00});
    chk("rst.u2", {tx2, txBusy2, txDone2, rxBusy2, rxDone2, rxErr2, out2}, {1'b1, 5'b0, 8'h00});
    repeat (4) @(negedge clk);
    reset = 0;
    repeat (4) @(negedge clk);
    mon1On = 1; mon2On = 1;

    // full-duplex A5 after reset
    in1 = 8'hA5; in2 = 8'hA5;
    q1.push_back('{data: 8'hA5, done: 1'b1, err: 1'b0});
    q2.push_back('{data: 8'hA5, done: 1'b1, err: 1'b0});
    txStart1 = 1; txStart2 = 1;
    waitTx1Low();
    txStart1 = 0; txStart2 = 0;
    repeat (11 * BAUD) @(negedge clk);
    chk("q1.drainF", q1.size(), 0);
    chk("q2.drainF", q2.size(), 0);
    chk("txDone.both", {txDone1, txDone2, txBusy1, txBusy2}, 4'b1100);
    chk("rx1.outF", out1, 8'hA5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
